if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//   Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the decode stage.
//   Owns the PC, drives the instruction ROM (combinational read, data valid the same cycle as address),
//   and registers {pc, inst} into decode. Handles pipeline stall, flush to an exception vector,
//   and branch redirect from decode, including a redirect that arrives while the PC is stalled.
// PARAMETERS
//   RESET_PC   32'h0000_0000   first fetch address after reset
//   PC_STEP    4               byte increment per sequential fetch
// PORTS
//   clk              in   1    clock; all state updates on rising edge
//   rst              in   1    synchronous reset, active-high
//   stall            in   6    stall vector; [0]=PC hold, [1]=IF hold, [2]=ID hold, [5:3] ignored here
//   flush            in   1    pipeline flush (exception); highest priority after rst
//   new_pc_i         in   32   flush target address
//   branch_flag_i    in   1    decode requests redirect
//   branch_target_i  in   32   redirect target
//   rom_data_i       in   32   instruction word at rom_addr_o
//   rom_ce_o         out  1    ROM chip enable
//   rom_addr_o       out  32   current PC / ROM address
//   id_pc_o          out  32   PC of instruction presented to decode
//   id_inst_o        out  32   instruction presented to decode
// BEHAVIOUR
//   Reset (rst=1 at edge): rom_ce_o=0, rom_addr_o=RESET_PC, id_pc_o=0, id_inst_o=0, pending cleared.
//   PC state machine: IDLE (ce=0) -> FETCH (ce=1) on first edge with rst=0; stays FETCH until rst.
//     In IDLE, rom_addr_o holds RESET_PC; first fetched address is RESET_PC.
//   Next-PC priority in FETCH, per edge:
//     1 flush=1           : pc<=new_pc_i; pending cleared
//     2 stall[0]=1        : pc holds; if branch_flag_i=1 latch pend_tgt<=branch_target_i, pending<=1
//                           (later branch during same stall overwrites pend_tgt)
//     3 branch_flag_i=1   : pc<=branch_target_i; pending cleared (live request beats pending)
//     4 pending=1         : pc<=pend_tgt; pending<=0
//     5 otherwise         : pc<=pc+PC_STEP, 32-bit wrap (32'hFFFF_FFFC -> 32'h0000_0000)
//   Branch has one delay slot: the instruction fetched in the cycle the branch is in decode still passes.
//   IF/ID register, per edge:
//     rst or flush                 : id_pc_o<=0, id_inst_o<=0 (NOP bubble)
//     stall[1]=1 and stall[2]=0    : id_pc_o<=0, id_inst_o<=0 (insert bubble)
//     stall[1]=1 and stall[2]=1    : hold
//     stall[1]=0                   : id_pc_o<=rom_addr_o; id_inst_o<=rom_ce_o ? rom_data_i : 0
//   Latency: instruction at address A appears on id_inst_o one edge after rom_addr_o=A.
//   Flush mid-stall: flush wins; pc and IF/ID update despite stall bits.
//   rst mid-operation: immediate return to IDLE on that edge; pending discarded.
//   No combinational path from inputs to outputs; all outputs are registers.
// TESTING
//   T1 reset release: rst 1->0 -> ce=0 one cycle, then addr 0,4,8,C; id_pc_o lags addr by one edge.
//   T2 branch: rom returns branch at 8, branch_flag_i=1 with target 40 while id_pc_o=8 -> addr seq 8,C,40,44.
//   T3 branch during stall: stall=6'b000111 with branch_flag_i=1, tgt 80, 3 cycles -> addr holds, id outputs hold;
//      release -> next addr 80.
//   T4 bubble: stall=6'b000011 -> id_inst_o=0, id_pc_o=0 next edge, addr holds.
//   T5 flush over stall: stall=6'b000111, flush=1, new_pc_i=20 -> addr=20, id outputs 0, pending cleared.
//   T6 wrap: force pc=FFFF_FFFC, no stall -> next addr 0000_0000.

Source files
------------

// File: rtl/if_stage.sv
// ============================================================================
//  Module      : if_stage
//  Description : Instruction fetch stage (PC, ROM drive, redirect/flush
//                handling) and the IF/ID pipeline register feeding decode.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] rom_data_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o
);

    localparam logic [31:0] c_pc_step = 32'(PC_STEP);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_pend;
    logic        w_pend_nxt;
    logic [31:0] r_pend_tgt;
    logic [31:0] w_pend_tgt_nxt;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;

    // Upper stall bits belong to later stages.
    logic w_unused_stall;
    assign w_unused_stall = ^stall[5:3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_FETCH;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next-PC selection; a redirect seen while the PC is held is parked in
    // r_pend_tgt and applied on the first unstalled edge unless superseded.
    always_comb begin
        w_pc_nxt       = r_pc;
        w_pend_nxt     = r_pend;
        w_pend_tgt_nxt = r_pend_tgt;
        if (r_state == S_FETCH) begin
            if (flush) begin
                w_pc_nxt   = new_pc_i;
                w_pend_nxt = 1'b0;
            end else if (stall[0]) begin
                if (branch_flag_i) begin
                    w_pend_tgt_nxt = branch_target_i;
                    w_pend_nxt     = 1'b1;
                end
            end else if (branch_flag_i) begin
                w_pc_nxt   = branch_target_i;
                w_pend_nxt = 1'b0;
            end else if (r_pend) begin
                w_pc_nxt   = r_pend_tgt;
                w_pend_nxt = 1'b0;
            end else begin
                w_pc_nxt = r_pc + c_pc_step;
            end
        end else begin
            w_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_pend     <= 1'b0;
            r_pend_tgt <= 32'h0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
        end
    end

    // IF/ID register: a held fetch with decode running gets a NOP bubble.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_id_pc   <= 32'h0;
            r_id_inst <= 32'h0;
        end else if (stall[1]) begin
            if (!stall[2]) begin
                r_id_pc   <= 32'h0;
                r_id_inst <= 32'h0;
            end
        end else begin
            r_id_pc   <= r_pc;
            r_id_inst <= (r_state == S_FETCH) ? rom_data_i : 32'h0;
        end
    end

    assign rom_ce_o   = (r_state == S_FETCH);
    assign rom_addr_o = r_pc;
    assign id_pc_o    = r_id_pc;
    assign id_inst_o  = r_id_inst;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
//  Module      : tb_if_stage
//  Description : Directed and randomized checks of if_stage against a
//                cycle-level behavioural model of the fetch rules.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [31:0] rom_data_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;

    int total = 0;
    int bad   = 0;

    // Model state
    bit          m_run;
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_tgt;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;

    if_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .new_pc_i       (new_pc_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .rom_data_i     (rom_data_i),
        .rom_ce_o       (rom_ce_o),
        .rom_addr_o     (rom_addr_o),
        .id_pc_o        (id_pc_o),
        .id_inst_o      (id_inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign rom_data_i = rom_word(rom_addr_o);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    // Advance the model by one clock edge from the currently driven inputs.
    task automatic model_edge();
        if (rst) begin
            m_run = 0; m_pc = 32'h0; m_pend = 0; m_tgt = 32'h0;
            m_id_pc = 32'h0; m_id_inst = 32'h0;
            return;
        end
        if (flush || (stall[1] && !stall[2])) begin
            m_id_pc = 32'h0; m_id_inst = 32'h0;
        end else if (!stall[1]) begin
            m_id_pc   = m_pc;
            m_id_inst = m_run ? rom_word(m_pc) : 32'h0;
        end
        if (!m_run) begin
            m_run = 1;
        end else if (flush) begin
            m_pc = new_pc_i; m_pend = 0;
        end else if (stall[0]) begin
            if (branch_flag_i) begin m_tgt = branch_target_i; m_pend = 1; end
        end else if (branch_flag_i) begin
            m_pc = branch_target_i; m_pend = 0;
        end else if (m_pend) begin
            m_pc = m_tgt; m_pend = 0;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input logic r, input logic [5:0] s, input logic f,
                        input logic [31:0] np, input logic b, input logic [31:0] bt);
        rst = r; stall = s; flush = f; new_pc_i = np; branch_flag_i = b; branch_target_i = bt;
        model_edge();
        @(posedge clk);
        #1;
        chk("ce",      {31'h0, rom_ce_o}, {31'h0, m_run});
        chk("addr",    rom_addr_o, m_pc);
        chk("id_pc",   id_pc_o,    m_id_pc);
        chk("id_inst", id_inst_o,  m_id_inst);
    endtask

    initial begin
        rst = 1'b1; stall = 6'h0; flush = 1'b0; new_pc_i = 32'h0;
        branch_flag_i = 1'b0; branch_target_i = 32'h0;
        m_run = 0; m_pc = 0; m_pend = 0; m_tgt = 0; m_id_pc = 0; m_id_inst = 0;

        // Reset state
        step(1, 6'h00, 0, 0, 0, 0);
        step(1, 6'h00, 0, 0, 0, 0);
        chk("rst_ce", {31'h0, rom_ce_o}, 32'h0);
        chk("rst_addr", rom_addr_o, 32'h0);

        // T1: release reset, sequential fetch
        step(0, 6'h00, 0, 0, 0, 0);
        chk("t1_first_addr", rom_addr_o, 32'h0);
        step(0, 6'h00, 0, 0, 0, 0);
        chk("t1_inst0", id_inst_o, rom_word(32'h0));
        step(0, 6'h00, 0, 0, 0, 0);
        step(0, 6'h00, 0, 0, 0, 0);
        chk("t1_addr_c", rom_addr_o, 32'hC);
        chk("t1_idpc_8", id_pc_o, 32'h8);

        // T2: branch in decode with delay slot
        step(0, 6'h00, 0, 0, 1, 32'h40);
        chk("t2_addr_40", rom_addr_o, 32'h40);
        chk("t2_slot_pc", id_pc_o, 32'hC);
        step(0, 6'h00, 0, 0, 0, 0);
        chk("t2_addr_44", rom_addr_o, 32'h44);

        // T3: branch during full stall, resolved on release
        repeat (3) step(0, 6'b000111, 0, 0, 1, 32'h80);
        chk("t3_hold_addr", rom_addr_o, 32'h44);
        chk("t3_hold_idpc", id_pc_o, 32'h40);
        step(0, 6'h00, 0, 0, 0, 0);
        chk("t3_addr_80", rom_addr_o, 32'h80);

        // T4: bubble insertion
        step(0, 6'b000011, 0, 0, 0, 0);
        chk("t4_bubble_inst", id_inst_o, 32'h0);
        chk("t4_hold_addr", rom_addr_o, 32'h80);

        // T5: flush beats stall and clears a parked redirect
        step(0, 6'b000111, 0, 0, 1, 32'h99C);
        step(0, 6'b000111, 1, 32'h20, 0, 0);
        chk("t5_addr_20", rom_addr_o, 32'h20);
        step(0, 6'h00, 0, 0, 0, 0);
        chk("t5_no_pend", rom_addr_o, 32'h24);

        // T6: 32-bit wrap
        step(0, 6'h00, 1, 32'hFFFF_FFFC, 0, 0);
        step(0, 6'h00, 0, 0, 0, 0);
        chk("t6_wrap", rom_addr_o, 32'h0);

        // Reset mid-operation returns to idle
        step(0, 6'b000001, 0, 0, 1, 32'h300);
        step(1, 6'h00, 0, 0, 0, 0);
        chk("midrst_ce", {31'h0, rom_ce_o}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic       r, f, b;
            logic [5:0] s;
            r = ($urandom_range(0, 63) == 0);
            f = ($urandom_range(0, 15) == 0);
            b = ($urandom_range(0, 4) == 0);
            s = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h0;
            step(r, s, f, $urandom & 32'hFFFF_FFFC, b, $urandom & 32'hFFFF_FFFC);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
